// File: rtl/elevator_pkg.sv
// elevator_pkg: shared encodings and width helper for the elevator request queue
package elevator_pkg;

    typedef enum logic [1:0] {
        REQ_CAR = 2'd0,
        REQ_UP  = 2'd1,
        REQ_DN  = 2'd2,
        REQ_RSV = 2'd3
    } req_e;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    function automatic int floor_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_target_sel.sv
// elevator_target_sel: collective-control next-stop search for a given travel direction
//   car_calls/up_calls/dn_calls : pending call vectors
//   car_floor                   : clamped car position
//   dir_nxt                     : direction the car will travel next
//   tgt_floor/tgt_valid         : selected stop and whether one exists
module elevator_target_sel
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = 7,
    parameter int FLOOR_W     = floor_w(FLOOR_COUNT)
) (
    input  logic [FLOOR_COUNT-1:0] car_calls,
    input  logic [FLOOR_COUNT-1:0] up_calls,
    input  logic [FLOOR_COUNT-1:0] dn_calls,
    input  logic [FLOOR_W-1:0]     car_floor,
    input  dir_e                   dir_nxt,
    output logic [FLOOR_W-1:0]     tgt_floor,
    output logic                   tgt_valid
);

    logic [FLOOR_COUNT-1:0] any_calls;

    assign any_calls = car_calls | up_calls | dn_calls;

    // Each direction runs its searches lowest priority first, so a later hit
    // overrides an earlier one; loop order makes each search keep the
    // lowest (descending loop) or highest (ascending loop) matching floor.
    always_comb begin
        tgt_floor = car_floor;
        tgt_valid = 1'b0;
        if (dir_nxt == DIR_UP) begin
            for (int i = FLOOR_COUNT - 1; i >= 0; i--)
                if (i > int'(car_floor) && any_calls[i]) begin
                    tgt_floor = FLOOR_W'(i);
                    tgt_valid = 1'b1;
                end
            for (int i = 0; i < FLOOR_COUNT; i++)
                if (i > int'(car_floor) && dn_calls[i]) begin
                    tgt_floor = FLOOR_W'(i);
                    tgt_valid = 1'b1;
                end
            for (int i = FLOOR_COUNT - 1; i >= 0; i--)
                if (i >= int'(car_floor) && (car_calls[i] || up_calls[i])) begin
                    tgt_floor = FLOOR_W'(i);
                    tgt_valid = 1'b1;
                end
        end else if (dir_nxt == DIR_DN) begin
            for (int i = 0; i < FLOOR_COUNT; i++)
                if (i < int'(car_floor) && any_calls[i]) begin
                    tgt_floor = FLOOR_W'(i);
                    tgt_valid = 1'b1;
                end
            for (int i = FLOOR_COUNT - 1; i >= 0; i--)
                if (i < int'(car_floor) && up_calls[i]) begin
                    tgt_floor = FLOOR_W'(i);
                    tgt_valid = 1'b1;
                end
            for (int i = 0; i < FLOOR_COUNT; i++)
                if (i <= int'(car_floor) && (car_calls[i] || dn_calls[i])) begin
                    tgt_floor = FLOOR_W'(i);
                    tgt_valid = 1'b1;
                end
        end else begin
            tgt_valid = any_calls[car_floor];
        end
    end

endmodule

// File: rtl/elevator_request_queue.sv
// elevator_request_queue: per-floor call registers with collective-control direction FSM
//   req_*      : call entry, acked/rejected by registered pulses one cycle later
//   svc_*      : service event clearing the served floor's calls
//   car_floor  : car position (values past the top floor clamp to the top floor)
//   *_calls, queue_data : registered pending-call views
//   tgt_*, dir : registered next stop and travel state, one cycle behind the calls
module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = 7,
    parameter int FLOOR_W     = floor_w(FLOOR_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [FLOOR_W-1:0]     req_floor,
    input  logic [1:0]             req_type,
    output logic                   req_ack,
    output logic                   req_err,
    input  logic                   svc_valid,
    input  logic [FLOOR_W-1:0]     svc_floor,
    input  logic [1:0]             svc_dir,
    input  logic [FLOOR_W-1:0]     car_floor,
    output logic [FLOOR_COUNT-1:0] car_calls,
    output logic [FLOOR_COUNT-1:0] up_calls,
    output logic [FLOOR_COUNT-1:0] dn_calls,
    output logic [FLOOR_COUNT-1:0] queue_data,
    output logic                   tgt_valid,
    output logic [FLOOR_W-1:0]     tgt_floor,
    output logic [1:0]             dir
);

    localparam logic [FLOOR_COUNT-1:0] ONE = {{(FLOOR_COUNT-1){1'b0}}, 1'b1};

    logic [FLOOR_COUNT-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;
    logic [FLOOR_COUNT-1:0] req_bit, svc_bit, all_calls, above, below;
    logic                   req_ok, svc_ok, ack_q, ack_d, err_q, err_d;
    logic                   any_above, any_below, sel_valid;
    logic                   tgt_valid_q, tgt_valid_d;
    logic [FLOOR_W-1:0]     tgt_floor_q, tgt_floor_d, sel_floor, cf;
    dir_e                   dir_q, dir_d;

    // Set is applied before clear so a same-edge clear of the same bit wins.
    always_comb begin
        req_ok  = int'(req_floor) < FLOOR_COUNT && req_type != REQ_RSV
                  && !(req_type == REQ_UP && int'(req_floor) == FLOOR_COUNT - 1)
                  && !(req_type == REQ_DN && req_floor == '0);
        ack_d   = req_valid && req_ok;
        err_d   = req_valid && !req_ok;
        svc_ok  = svc_valid && int'(svc_floor) < FLOOR_COUNT;
        req_bit = ack_d ? ONE << req_floor : '0;
        svc_bit = svc_ok ? ONE << svc_floor : '0;
        car_d   = (car_q | (req_type == REQ_CAR ? req_bit : '0)) & ~svc_bit;
        up_d    = (up_q | (req_type == REQ_UP ? req_bit : '0)) & ~(svc_dir != 2'd2 ? svc_bit : '0);
        dn_d    = (dn_q | (req_type == REQ_DN ? req_bit : '0)) & ~(svc_dir != 2'd1 ? svc_bit : '0);
    end

    always_comb begin
        cf        = (int'(car_floor) >= FLOOR_COUNT) ? FLOOR_W'(FLOOR_COUNT - 1) : car_floor;
        all_calls = car_q | up_q | dn_q;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            above[i] = i > int'(cf);
            below[i] = i < int'(cf);
        end
        any_above = |(all_calls & above);
        any_below = |(all_calls & below);
        dir_d     = (dir_q == DIR_DN && any_below) ? DIR_DN :
                    any_above ? DIR_UP : any_below ? DIR_DN : DIR_IDLE;
        tgt_valid_d = sel_valid;
        tgt_floor_d = sel_valid ? sel_floor : tgt_floor_q;
    end

    elevator_target_sel #(
        .FLOOR_COUNT (FLOOR_COUNT),
        .FLOOR_W     (FLOOR_W)
    ) u_target_sel (
        .car_calls (car_q),
        .up_calls  (up_q),
        .dn_calls  (dn_q),
        .car_floor (cf),
        .dir_nxt   (dir_d),
        .tgt_floor (sel_floor),
        .tgt_valid (sel_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_q       <= '0;
            up_q        <= '0;
            dn_q        <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            tgt_valid_q <= 1'b0;
            tgt_floor_q <= '0;
            dir_q       <= DIR_IDLE;
        end else begin
            car_q       <= car_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            tgt_valid_q <= tgt_valid_d;
            tgt_floor_q <= tgt_floor_d;
            dir_q       <= dir_d;
        end
    end

    assign car_calls  = car_q;
    assign up_calls   = up_q;
    assign dn_calls   = dn_q;
    assign queue_data = car_q | up_q | dn_q;
    assign req_ack    = ack_q;
    assign req_err    = err_q;
    assign tgt_valid  = tgt_valid_q;
    assign tgt_floor  = tgt_floor_q;
    assign dir        = dir_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// tb_elevator_request_queue: directed scenarios plus randomized run against a floor-level reference model
module tb_elevator_request_queue;

    localparam int FC = 7;
    localparam int FW = 3;

    logic          clk = 1'b0, reset = 1'b0;
    logic          req_valid = 1'b0, svc_valid = 1'b0;
    logic [FW-1:0] req_floor = '0, svc_floor = '0, car_floor = '0;
    logic [1:0]    req_type = '0, svc_dir = '0;
    logic          req_ack, req_err, tgt_valid;
    logic [FC-1:0] car_calls, up_calls, dn_calls, queue_data;
    logic [FW-1:0] tgt_floor;
    logic [1:0]    dir;

    int checks = 0, passed = 0;

    bit [FC-1:0] mc, mu, md;
    int          m_dir, m_tf;
    bit          m_tv, m_ack, m_err;

    elevator_request_queue #(.FLOOR_COUNT(FC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .req_type   (req_type),
        .req_ack    (req_ack),
        .req_err    (req_err),
        .svc_valid  (svc_valid),
        .svc_floor  (svc_floor),
        .svc_dir    (svc_dir),
        .car_floor  (car_floor),
        .car_calls  (car_calls),
        .up_calls   (up_calls),
        .dn_calls   (dn_calls),
        .queue_data (queue_data),
        .tgt_valid  (tgt_valid),
        .tgt_floor  (tgt_floor),
        .dir        (dir)
    );

    always #5 clk = ~clk;

    // Reference: floor-by-floor scan of the collective-control rules on the
    // calls as they stood before this edge, then apply the request and service.
    task automatic model_edge();
        int cf, tf, nd;
        bit ab, be, found, legal;
        bit [FC-1:0] anyc;
        cf   = (int'(car_floor) > FC - 1) ? FC - 1 : int'(car_floor);
        anyc = mc | mu | md;
        ab = 0;
        be = 0;
        for (int f = 0; f < FC; f++)
            if (anyc[f]) begin
                if (f > cf) ab = 1;
                if (f < cf) be = 1;
            end
        if (m_dir == 2) nd = be ? 2 : ab ? 1 : 0;
        else nd = ab ? 1 : be ? 2 : 0;
        found = 0;
        tf = cf;
        if (nd == 1) begin
            for (int f = cf; f < FC && !found; f++) if (mc[f] || mu[f]) begin tf = f; found = 1; end
            for (int f = FC - 1; f > cf && !found; f--) if (md[f]) begin tf = f; found = 1; end
            for (int f = cf + 1; f < FC && !found; f++) if (anyc[f]) begin tf = f; found = 1; end
        end else if (nd == 2) begin
            for (int f = cf; f >= 0 && !found; f--) if (mc[f] || md[f]) begin tf = f; found = 1; end
            for (int f = 0; f < cf && !found; f++) if (mu[f]) begin tf = f; found = 1; end
            for (int f = cf - 1; f >= 0 && !found; f--) if (anyc[f]) begin tf = f; found = 1; end
        end else begin
            found = anyc[cf];
        end
        m_dir = nd;
        m_tv  = found;
        if (found) m_tf = tf;
        legal = int'(req_floor) < FC && req_type != 2'd3
                && !(req_type == 2'd1 && int'(req_floor) == FC - 1)
                && !(req_type == 2'd2 && req_floor == 0);
        m_ack = req_valid && legal;
        m_err = req_valid && !legal;
        if (m_ack) begin
            if (req_type == 2'd0) mc[req_floor] = 1;
            if (req_type == 2'd1) mu[req_floor] = 1;
            if (req_type == 2'd2) md[req_floor] = 1;
        end
        if (svc_valid && int'(svc_floor) < FC) begin
            mc[svc_floor] = 0;
            if (svc_dir != 2'd2) mu[svc_floor] = 0;
            if (svc_dir != 2'd1) md[svc_floor] = 0;
        end
    endtask

    task automatic step(input bit rv, input int rf, input int rt,
                        input bit sv, input int sf, input int sd, input int cfl);
        req_valid = rv;
        req_floor = FW'(rf);
        req_type  = 2'(rt);
        svc_valid = sv;
        svc_floor = FW'(sf);
        svc_dir   = 2'(sd);
        car_floor = FW'(cfl);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        req_valid = 0;
        svc_valid = 0;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        mc = '0; mu = '0; md = '0;
        m_dir = 0; m_tf = 0; m_tv = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({car_calls, up_calls, dn_calls, queue_data} !== '0)
            $display("FAIL reset_calls: got %h/%h/%h/%h required 0", car_calls, up_calls, dn_calls, queue_data);
        else passed++;
        checks++;
        if ({dir, tgt_valid, req_ack, req_err, tgt_floor} !== '0)
            $display("FAIL reset_ctrl: dir=%0d tv=%b ack=%b err=%b tf=%0d required all 0", dir, tgt_valid, req_ack, req_err, tgt_floor);
        else passed++;
    endtask

    task automatic test_single_car();
        do_reset();
        step(1, 4, 0, 0, 0, 0, 0);
        checks++;
        if ({req_ack, car_calls} !== {1'b1, 7'h10})
            $display("FAIL single_ack: ack=%b car=%h required 1/10", req_ack, car_calls);
        else passed++;
        checks++;
        if (dir !== 2'd0)
            $display("FAIL single_lag: dir=%0d required 0 one edge after request", dir);
        else passed++;
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({dir, tgt_valid, tgt_floor} !== {2'd1, 1'b1, 3'd4})
            $display("FAIL single_tgt: dir=%0d tv=%b tf=%0d required 1/1/4", dir, tgt_valid, tgt_floor);
        else passed++;
        step(0, 0, 0, 1, 4, 0, 4);
        checks++;
        if (car_calls !== '0)
            $display("FAIL single_svc: car=%h required 0", car_calls);
        else passed++;
        step(0, 0, 0, 0, 0, 0, 4);
        checks++;
        if ({dir, tgt_valid, tgt_floor} !== {2'd0, 1'b0, 3'd4})
            $display("FAIL single_idle: dir=%0d tv=%b tf=%0d required 0/0/4", dir, tgt_valid, tgt_floor);
        else passed++;
    endtask

    task automatic test_collective();
        do_reset();
        step(1, 5, 0, 0, 0, 0, 2);
        step(1, 3, 1, 0, 0, 0, 2);
        step(1, 6, 2, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 0, 2);
        checks++;
        if ({dir, tgt_valid, tgt_floor, queue_data} !== {2'd1, 1'b1, 3'd3, 7'h68})
            $display("FAIL coll_first: dir=%0d tv=%b tf=%0d q=%h required 1/1/3/68", dir, tgt_valid, tgt_floor, queue_data);
        else passed++;
        step(0, 0, 0, 1, 3, 1, 3);
        step(0, 0, 0, 0, 0, 0, 3);
        checks++;
        if ({dir, tgt_floor} !== {2'd1, 3'd5})
            $display("FAIL coll_second: dir=%0d tf=%0d required 1/5", dir, tgt_floor);
        else passed++;
        step(0, 0, 0, 1, 5, 1, 5);
        step(0, 0, 0, 0, 0, 0, 5);
        checks++;
        if ({dir, tgt_valid, tgt_floor} !== {2'd1, 1'b1, 3'd6})
            $display("FAIL coll_dn_above: dir=%0d tv=%b tf=%0d required 1/1/6", dir, tgt_valid, tgt_floor);
        else passed++;
        step(0, 0, 0, 1, 6, 2, 6);
        step(0, 0, 0, 0, 0, 0, 6);
        checks++;
        if ({dir, tgt_valid, queue_data} !== {2'd0, 1'b0, 7'h00})
            $display("FAIL coll_idle: dir=%0d tv=%b q=%h required 0/0/00", dir, tgt_valid, queue_data);
        else passed++;
    endtask

    task automatic test_reversal();
        do_reset();
        step(1, 1, 2, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 0, 5);
        checks++;
        if ({dir, tgt_valid, tgt_floor} !== {2'd2, 1'b1, 3'd1})
            $display("FAIL rev_down: dir=%0d tv=%b tf=%0d required 2/1/1", dir, tgt_valid, tgt_floor);
        else passed++;
        step(0, 0, 0, 1, 1, 2, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({dir, tgt_valid, tgt_floor} !== {2'd2, 1'b1, 3'd0})
            $display("FAIL rev_floor0: dir=%0d tv=%b tf=%0d required 2/1/0", dir, tgt_valid, tgt_floor);
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        step(1, 6, 1, 0, 0, 0, 0);
        checks++;
        if ({req_err, req_ack, up_calls} !== {2'b10, 7'h00})
            $display("FAIL ill_up_top: err=%b ack=%b up=%h required 1/0/00", req_err, req_ack, up_calls);
        else passed++;
        step(1, 7, 0, 0, 0, 0, 0);
        checks++;
        if ({req_err, req_ack, queue_data} !== {2'b10, 7'h00})
            $display("FAIL ill_floor7: err=%b ack=%b q=%h required 1/0/00", req_err, req_ack, queue_data);
        else passed++;
        step(1, 2, 3, 0, 0, 0, 0);
        checks++;
        if ({req_err, req_ack, queue_data} !== {2'b10, 7'h00})
            $display("FAIL ill_type3: err=%b ack=%b q=%h required 1/0/00", req_err, req_ack, queue_data);
        else passed++;
        step(1, 0, 2, 0, 0, 0, 0);
        checks++;
        if ({req_err, req_ack, dn_calls} !== {2'b10, 7'h00})
            $display("FAIL ill_dn_bottom: err=%b ack=%b dn=%h required 1/0/00", req_err, req_ack, dn_calls);
        else passed++;
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        checks++;
        if ({req_ack, req_err, car_calls} !== {2'b10, 7'h04})
            $display("FAIL dup_car: ack=%b err=%b car=%h required 1/0/04", req_ack, req_err, car_calls);
        else passed++;
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({req_ack, req_err} !== 2'b00)
            $display("FAIL pulse_width: ack=%b err=%b required 0/0", req_ack, req_err);
        else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, 3, 1, 1, 3, 1, 3);
        checks++;
        if ({req_ack, up_calls[3]} !== 2'b10)
            $display("FAIL sim_same: ack=%b up3=%b required 1/0", req_ack, up_calls[3]);
        else passed++;
        step(1, 4, 0, 1, 3, 0, 3);
        checks++;
        if ({req_ack, car_calls} !== {1'b1, 7'h10})
            $display("FAIL sim_diff: ack=%b car=%h required 1/10", req_ack, car_calls);
        else passed++;
        step(0, 0, 0, 1, 7, 0, 3);
        checks++;
        if (queue_data !== 7'h10)
            $display("FAIL svc_oor: q=%h required 10", queue_data);
        else passed++;
    endtask

    task automatic test_boundary();
        do_reset();
        step(1, 6, 0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 7);
        checks++;
        if ({dir, tgt_valid, tgt_floor} !== {2'd0, 1'b1, 3'd6})
            $display("FAIL clamp_here: dir=%0d tv=%b tf=%0d required 0/1/6", dir, tgt_valid, tgt_floor);
        else passed++;
        step(1, 2, 0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 7);
        checks++;
        if ({dir, tgt_floor} !== {2'd2, 3'd6})
            $display("FAIL clamp_down: dir=%0d tf=%0d required 2/6", dir, tgt_floor);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 5, 0, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 0;
        #1;
        checks++;
        if ({queue_data, dir, tgt_valid, tgt_floor, req_ack, req_err} !== '0)
            $display("FAIL async_reset: q=%h dir=%0d tv=%b tf=%0d ack=%b required all 0", queue_data, dir, tgt_valid, tgt_floor, req_ack);
        else passed++;
        do_reset();
    endtask

    task automatic test_random();
        int cfl;
        cfl = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) cfl = $urandom_range(7);
            step($urandom_range(9) < 7, $urandom_range(7), $urandom_range(3),
                 $urandom_range(9) < 3, $urandom_range(7), $urandom_range(2), cfl);
            checks++;
            if ({car_calls, up_calls, dn_calls} !== {mc, mu, md})
                $display("FAIL rnd_calls@%0d: got %h/%h/%h required %h/%h/%h", n, car_calls, up_calls, dn_calls, mc, mu, md);
            else passed++;
            checks++;
            if (queue_data !== (mc | mu | md))
                $display("FAIL rnd_queue@%0d: got %h required %h", n, queue_data, mc | mu | md);
            else passed++;
            checks++;
            if ({req_ack, req_err} !== {m_ack, m_err})
                $display("FAIL rnd_ackerr@%0d: got %b%b required %b%b", n, req_ack, req_err, m_ack, m_err);
            else passed++;
            checks++;
            if (dir !== 2'(m_dir))
                $display("FAIL rnd_dir@%0d: got %0d required %0d", n, dir, m_dir);
            else passed++;
            checks++;
            if ({tgt_valid, tgt_floor} !== {m_tv, FW'(m_tf)})
                $display("FAIL rnd_tgt@%0d: got %b/%0d required %b/%0d", n, tgt_valid, tgt_floor, m_tv, m_tf);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_car();
        test_collective();
        test_reversal();
        test_illegal();
        test_simultaneous();
        test_boundary();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/elevator_request_queue.md
Name: elevator_request_queue

Overview:
- Parametrised successor to elevator_queue. Holds pending car calls, hall-up calls and hall-down calls per floor.
- Clears calls when the car services a floor.
- Runs a collective-control direction FSM that registers the next target floor for the motion controller.
- Keeps a flat queue_data view so existing consumers of the single-vector queue still work.

Parameters:
- FLOOR_COUNT, 7, number of floors (≥2); floor 0 is the lowest.
- FLOOR_W, $clog2(FLOOR_COUNT), floor index width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state
- req_valid  in  1  new call present this cycle
- req_floor  in  FLOOR_W  floor of the call
- req_type  in  2  0 car, 1 hall-up, 2 hall-down, 3 reserved
- req_ack  out  1  registered pulse: previous-cycle request accepted
- req_err  out  1  registered pulse: previous-cycle request rejected
- svc_valid  in  1  car stopped with doors open this cycle
- svc_floor  in  FLOOR_W  serviced floor
- svc_dir  in  2  direction served: 1 up, 2 down, 0 none
- car_floor  in  FLOOR_W  current car position, stable while sampled
- car_calls  out  FLOOR_COUNT  pending car-call bits
- up_calls  out  FLOOR_COUNT  pending hall-up bits
- dn_calls  out  FLOOR_COUNT  pending hall-down bits
- queue_data  out  FLOOR_COUNT  car_calls | up_calls | dn_calls
- tgt_valid  out  1  tgt_floor holds a pending stop
- tgt_floor  out  FLOOR_W  next stop
- dir  out  2  FSM state: 0 IDLE, 1 UP, 2 DOWN

Behaviour:
- **Reset (reset=0, asynchronous):**
  - All call bits, req_ack, req_err and tgt_valid go to 0.
  - tgt_floor=0, dir=IDLE.
  - A reset mid-operation discards all pending calls.
- **Request acceptance:**
  - On a rising edge with req_valid=1, the request is rejected if any of these hold:
    - req_floor ≥ FLOOR_COUNT
    - req_type=3
    - hall-up at floor FLOOR_COUNT-1
    - hall-down at floor 0
  - Rejected request: req_err=1 next cycle, no state change.
  - Otherwise the matching bit is set and req_ack=1 next cycle. A duplicate (bit already set) is still acked; no change.
- **Service:**
  - On an edge with svc_valid=1 and svc_floor valid, car_calls[svc_floor] is cleared.
  - svc_dir=1 also clears up_calls[svc_floor]; svc_dir=2 also clears dn_calls[svc_floor]; svc_dir=0 clears both hall bits.
  - An out-of-range svc_floor is ignored.
- **Simultaneous set and clear:**
  - Same floor and same bit: clear wins; the request is still acked.
  - Different bits: both take effect on the same edge.
- **Latency:**
  - Call bits and queue_data update on the edge after req/svc; they are registered outputs.
  - tgt_floor, tgt_valid and dir are registered from the current call bits, so they lag call bits by one cycle.
  - A request therefore reaches the target two edges after req_valid.
- **Definitions:**
  - "Above" means floors > car_floor; "below" means floors < car_floor.
  - any_above / any_below = any call bit set in that range.
  - here = any bit at car_floor.
- **FSM next state:**
  - IDLE: any_above → UP; else any_below → DOWN; else IDLE. Tie (both) → UP.
  - UP: any_above → UP; else any_below → DOWN; else IDLE.
  - DOWN: any_below → DOWN; else any_above → UP; else IDLE.
- **Target selection, evaluated on the next state:**
  - UP:
    1. Lowest floor ≥ car_floor with a car or up call (car_floor counts only if it has that call).
    2. Else highest floor with a dn call above.
    3. Else lowest above with any call.
  - DOWN: mirror of UP (highest ≤ car_floor with car/dn call; else lowest up call below; else highest below with any call).
  - IDLE: here → tgt_floor=car_floor, tgt_valid=1; else tgt_valid=0 and tgt_floor holds its last value.
- **Boundary behaviour:**
  - At floor FLOOR_COUNT-1 there is no "above", so UP always reverses or idles.
  - Floor 0 mirrors this for DOWN.
  - car_floor ≥ FLOOR_COUNT is treated as FLOOR_COUNT-1.
- **Constraint:** purely a single clock domain; no combinational paths from inputs to outputs.

Decomposition:
- Package elevator_pkg holds:
  - req_type encodings (REQ_CAR, REQ_UP, REQ_DN)
  - dir encodings (DIR_IDLE, DIR_UP, DIR_DN)
  - the FLOOR_W function
- One natural sub-module: elevator_target_sel. It is purely combinational and takes the call vectors, car_floor and next dir. It produces the target floor and valid, using priority-encoder searches above and below.
- Request/service registers and the FSM stay in the top module.

Test Plan:
- **Reset/idle:** hold reset=0 for 3 cycles, release → all calls 0, dir=0, tgt_valid=0. Assert reset=0 asynchronously mid-run with calls pending → all clear immediately.
- **Single car call upward:** car_floor=0, car call floor 4 → req_ack at +1, car_calls=0x10 at +1, dir=UP, tgt_floor=4 at +2. Then svc floor 4 dir 0 → car_calls=0, dir=IDLE at +2.
- **Collective ordering:** car_floor=2, dir UP; calls: car 5, up 3, dn 6 → tgt=3. After servicing 3 up → tgt=5; after 5 → tgt=6 with dir UP. After servicing 6 dn → IDLE.
- **Reversal:** car_floor=5, only dn call at 1 and car call at 0 → dir=DOWN, tgt=1. Service 1 dn → tgt=0.
- **Illegal and duplicate requests:**
  - hall-up at floor 6 → req_err, no bit set.
  - floor 7 → req_err.
  - type 3 → req_err.
  - duplicate car call 2 → req_ack, car_calls unchanged.
- **Simultaneous set and clear:** up call floor 3 and svc floor 3 dir 1 on the same edge → req_ack=1, up_calls[3]=0. Car call 4 with svc floor 3 → car_calls[4]=1.
